// File: rtl/pinball_pkg.sv
// Shared types and idle-level constants for the pinball input conditioner.
package pinball_pkg;

    // Conditioner mode: wait for quiet inputs after reset, then run.
    typedef enum logic {
        SETTLE = 1'b0,
        RUN    = 1'b1
    } cond_state_t;

    // Resting level of each sensor class when no ball is interacting.
    localparam logic TARGET_IDLE = 1'b0;
    localparam logic LOSE_IDLE   = 1'b0;
    localparam logic TUNNEL_IDLE = 1'b1;

endpackage : pinball_pkg

// File: rtl/pinball_input_cond_if.sv
// Bundle of raw sensor inputs and conditioned outputs between the
// playfield sensors and the game FSM.
interface pinball_input_cond_if #(
    parameter int N_TUNNEL = 4
);

    // Raw, asynchronous playfield sensors
    logic                raw_target;
    logic                raw_lose_arch;
    logic [N_TUNNEL-1:0] raw_tunnel_p;

    // Conditioned, clk-synchronous outputs
    logic                target;
    logic                lose_arch;
    logic [N_TUNNEL-1:0] tunnel_p;
    logic                target_hit;
    logic [N_TUNNEL-1:0] tunnel_hit;
    logic                enable_FSM;
    logic [N_TUNNEL-1:0] sensor_fault;

    // Sensor side: drives raw levels, observes conditioned results
    modport master (
        output raw_target,
        output raw_lose_arch,
        output raw_tunnel_p,
        input  target,
        input  lose_arch,
        input  tunnel_p,
        input  target_hit,
        input  tunnel_hit,
        input  enable_FSM,
        input  sensor_fault
    );

    // Conditioner side: consumes raw levels, produces conditioned results
    modport slave (
        input  raw_target,
        input  raw_lose_arch,
        input  raw_tunnel_p,
        output target,
        output lose_arch,
        output tunnel_p,
        output target_hit,
        output tunnel_hit,
        output enable_FSM,
        output sensor_fault
    );

endinterface : pinball_input_cond_if

// File: rtl/sensor_debounce.sv
// One sensor channel: 2-flop synchronizer, persistence-count debouncer
// and a one-cycle pulse when the accepted level moves to its active value.
module sensor_debounce #(
    parameter int   DEB_CYCLES = 16,
    parameter logic IDLE       = 1'b0
) (
    input  logic clk,
    input  logic reset,       // asynchronous, active-low
    input  logic raw,
    output logic level,
    output logic rise_pulse,  // pulse on transition to the active (non-idle) level
    output logic busy         // a candidate level change is being timed
);

    localparam int              DEB_W   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DEB_W-1:0] CNT_MAX = DEB_W'(DEB_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             stable_q, stable_d;
    logic [DEB_W-1:0] cnt_q, cnt_d;
    logic             pulse_q, pulse_d;

    // Synchronizer shift and debounce decision for the next edge
    always_comb begin
        sync1_d  = raw;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        pulse_d  = 1'b0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_MAX) begin
                // New level has persisted long enough: accept it
                stable_d = sync2_q;
                cnt_d    = '0;
                pulse_d  = (sync2_q != IDLE);
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            // Any return to the accepted level discards the candidate
            cnt_d = '0;
        end
    end

    // Channel state registers; reset drops everything back to idle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q  <= IDLE;
            sync2_q  <= IDLE;
            stable_q <= IDLE;
            cnt_q    <= '0;
            pulse_q  <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            pulse_q  <= pulse_d;
        end
    end

    assign level      = stable_q;
    assign rise_pulse = pulse_q;
    assign busy       = (cnt_q != '0);

endmodule : sensor_debounce

// File: rtl/pinball_input_cond.sv
// Pinball input conditioner: debounces all playfield sensors, holds the
// game FSM off until inputs are quiet after reset, and flags tunnel
// sensors that stay blocked for too long.
module pinball_input_cond
    import pinball_pkg::*;
#(
    parameter int N_TUNNEL      = 4,
    parameter int DEB_CYCLES    = 16,
    parameter int SETTLE_CYCLES = 64,
    parameter int STUCK_CYCLES  = 4096
) (
    input  logic                  clk,
    input  logic                  reset,   // asynchronous, active-low
    pinball_input_cond_if.slave   bus
);

    localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int STUCK_W  = (STUCK_CYCLES > 1) ? $clog2(STUCK_CYCLES) : 1;
    localparam logic [SETTLE_W-1:0] SETTLE_MAX = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [STUCK_W-1:0]  STUCK_MAX  = STUCK_W'(STUCK_CYCLES - 1);

    logic                target_lvl;
    logic                target_rise;
    logic                lose_lvl;
    logic                lose_rise_unused;
    logic [N_TUNNEL-1:0] tunnel_lvl;
    logic [N_TUNNEL-1:0] tunnel_rise;
    logic [N_TUNNEL+1:0] busy;
    logic                all_idle;

    cond_state_t         state_q, state_d;
    logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
    logic                enable_q, enable_d;
    logic [STUCK_W-1:0]  stuck_cnt_q [N_TUNNEL];
    logic [STUCK_W-1:0]  stuck_cnt_d [N_TUNNEL];
    logic [N_TUNNEL-1:0] fault_q, fault_d;

    // ---------------------------------------------------------------
    // Per-channel conditioning
    // ---------------------------------------------------------------
    sensor_debounce #(
        .DEB_CYCLES (DEB_CYCLES),
        .IDLE       (TARGET_IDLE)
    ) u_target (
        .clk        (clk),
        .reset      (reset),
        .raw        (bus.raw_target),
        .level      (target_lvl),
        .rise_pulse (target_rise),
        .busy       (busy[0])
    );

    // Lose arch only exports a level; its pulse is not consumed
    sensor_debounce #(
        .DEB_CYCLES (DEB_CYCLES),
        .IDLE       (LOSE_IDLE)
    ) u_lose (
        .clk        (clk),
        .reset      (reset),
        .raw        (bus.raw_lose_arch),
        .level      (lose_lvl),
        .rise_pulse (lose_rise_unused),
        .busy       (busy[1])
    );

    // Tunnel beams idle high, so their pulse marks a 1->0 (ball present)
    generate
        for (genvar gi = 0; gi < N_TUNNEL; gi++) begin : g_tunnel
            sensor_debounce #(
                .DEB_CYCLES (DEB_CYCLES),
                .IDLE       (TUNNEL_IDLE)
            ) u_tunnel (
                .clk        (clk),
                .reset      (reset),
                .raw        (bus.raw_tunnel_p[gi]),
                .level      (tunnel_lvl[gi]),
                .rise_pulse (tunnel_rise[gi]),
                .busy       (busy[gi+2])
            );
        end
    endgenerate

    // Quiet means every accepted level is idle and no change is pending
    assign all_idle = (target_lvl == TARGET_IDLE) &&
                      (lose_lvl == LOSE_IDLE) &&
                      (tunnel_lvl == {N_TUNNEL{TUNNEL_IDLE}}) &&
                      (busy == '0);

    // ---------------------------------------------------------------
    // Settle / run control
    // ---------------------------------------------------------------

    // Next-state: count consecutive quiet cycles, then enable for good
    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        enable_d     = enable_q;
        case (state_q)
            SETTLE: begin
                if (all_idle) begin
                    if (settle_cnt_q == SETTLE_MAX) begin
                        state_d  = RUN;
                        enable_d = 1'b1;
                    end else begin
                        settle_cnt_d = settle_cnt_q + 1'b1;
                    end
                end else begin
                    settle_cnt_d = '0;
                end
            end
            RUN: begin
                enable_d = 1'b1;
            end
            default: begin
                state_d      = SETTLE;
                settle_cnt_d = '0;
                enable_d     = 1'b0;
            end
        endcase
    end

    // Control registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= SETTLE;
            settle_cnt_q <= '0;
            enable_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            enable_q     <= enable_d;
        end
    end

    // ---------------------------------------------------------------
    // Stuck tunnel sensor detection
    // ---------------------------------------------------------------

    // Time continuous blocked periods per beam; faults are sticky
    always_comb begin
        stuck_cnt_d = stuck_cnt_q;
        fault_d     = fault_q;
        if (state_q == RUN) begin
            for (int i = 0; i < N_TUNNEL; i++) begin
                if (tunnel_lvl[i] != TUNNEL_IDLE) begin
                    if (stuck_cnt_q[i] == STUCK_MAX) begin
                        fault_d[i] = 1'b1;
                    end else begin
                        stuck_cnt_d[i] = stuck_cnt_q[i] + 1'b1;
                    end
                end else begin
                    stuck_cnt_d[i] = '0;
                end
            end
        end
    end

    // Stuck counters and fault flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_TUNNEL; i++) begin
                stuck_cnt_q[i] <= '0;
            end
            fault_q <= '0;
        end else begin
            stuck_cnt_q <= stuck_cnt_d;
            fault_q     <= fault_d;
        end
    end

    // ---------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------
    assign bus.target       = target_lvl;
    assign bus.lose_arch    = lose_lvl;
    assign bus.tunnel_p     = tunnel_lvl;
    assign bus.target_hit   = target_rise;
    assign bus.tunnel_hit   = tunnel_rise;
    assign bus.enable_FSM   = enable_q;
    assign bus.sensor_fault = fault_q;

endmodule : pinball_input_cond

// File: tb/tb_pinball_input_cond.sv
// Directed bench for pinball_input_cond with small timing parameters.
module tb_pinball_input_cond;

    localparam int NT = 4;

    logic clk;
    logic reset;

    pinball_input_cond_if #(.N_TUNNEL(NT)) bus ();

    pinball_input_cond #(
        .N_TUNNEL      (NT),
        .DEB_CYCLES    (4),
        .SETTLE_CYCLES (8),
        .STUCK_CYCLES  (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          rt;
        logic          rl;
        logic [NT-1:0] rtun;
        logic          et;
        logic          el;
        logic [NT-1:0] etun;
        logic          eth;
        logic [NT-1:0] etunh;
        logic          een;
        logic [NT-1:0] ef;
    } vec_t;

    vec_t vq[$];
    int   total;
    int   bad;

    task automatic chk(input string nm, input int idx,
                       input logic [NT-1:0] act, input logic [NT-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s vec=%0d got=%b want=%b t=%0t", nm, idx, act, exp, $time);
        end
    endtask

    task automatic push(input logic rt, input logic rl, input logic [NT-1:0] rtun,
                        input logic et, input logic el, input logic [NT-1:0] etun,
                        input logic eth, input logic [NT-1:0] etunh,
                        input logic een, input logic [NT-1:0] ef);
        vec_t v;
        v.rt = rt; v.rl = rl; v.rtun = rtun;
        v.et = et; v.el = el; v.etun = etun;
        v.eth = eth; v.etunh = etunh; v.een = een; v.ef = ef;
        vq.push_back(v);
    endtask

    // Drive one vector at a falling edge, check after the next rising edge
    task automatic run_vec(input vec_t v, input int idx);
        bus.raw_target    = v.rt;
        bus.raw_lose_arch = v.rl;
        bus.raw_tunnel_p  = v.rtun;
        @(posedge clk);
        @(negedge clk);
        $display("vec %0d: raw t=%b l=%b tun=%b -> t=%b l=%b tun=%b th=%b tunh=%b en=%b flt=%b",
                 idx, v.rt, v.rl, v.rtun, bus.target, bus.lose_arch, bus.tunnel_p,
                 bus.target_hit, bus.tunnel_hit, bus.enable_FSM, bus.sensor_fault);
        chk("target",       idx, {3'b0, bus.target},     {3'b0, v.et});
        chk("lose_arch",    idx, {3'b0, bus.lose_arch},  {3'b0, v.el});
        chk("tunnel_p",     idx, bus.tunnel_p,           v.etun);
        chk("target_hit",   idx, {3'b0, bus.target_hit}, {3'b0, v.eth});
        chk("tunnel_hit",   idx, bus.tunnel_hit,         v.etunh);
        chk("enable_FSM",   idx, {3'b0, bus.enable_FSM}, {3'b0, v.een});
        chk("sensor_fault", idx, bus.sensor_fault,       v.ef);
    endtask

    logic [NT-1:0] rtun, etun, eh;
    vec_t          idle_v;

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        bus.raw_target    = 1'b0;
        bus.raw_lose_arch = 1'b0;
        bus.raw_tunnel_p  = '1;

        // Settle after reset: enable on the 8th edge
        for (int v = 1; v <= 8; v++)
            push(0, 0, 4'hF, 0, 0, 4'hF, 0, 4'h0, (v == 8), 4'h0);
        // Two-cycle target glitch is rejected
        for (int v = 1; v <= 8; v++)
            push((v <= 2), 0, 4'hF, 0, 0, 4'hF, 0, 4'h0, 1, 4'h0);
        // Target held 10 cycles: accepted on 6, released on 16, one pulse
        for (int v = 1; v <= 20; v++)
            push((v <= 10), 0, 4'hF, (v >= 6 && v <= 15), 0, 4'hF, (v == 6), 4'h0, 1, 4'h0);
        // Lose arch held 8 cycles: level only, no pulse
        for (int v = 1; v <= 16; v++)
            push(0, (v <= 8), 4'hF, 0, (v >= 6 && v <= 13), 4'hF, 0, 4'h0, 1, 4'h0);
        // Target and tunnel 1 together: simultaneous pulses
        for (int v = 1; v <= 16; v++)
            push((v <= 8), 0, (v <= 8) ? 4'b1101 : 4'hF,
                 (v >= 6 && v <= 13), 0, (v >= 6 && v <= 13) ? 4'b1101 : 4'hF,
                 (v == 6), (v == 6) ? 4'b0010 : 4'h0, 1, 4'h0);
        // Tunnel walk: each beam blocked 10 cycles in turn
        for (int v = 1; v <= 48; v++) begin
            rtun = '1; etun = '1; eh = '0;
            for (int i = 0; i < NT; i++) begin
                if (v >= 10*i+1 && v <= 10*i+10) rtun[i] = 1'b0;
                if (v >= 10*i+6 && v <= 10*i+15) etun[i] = 1'b0;
                if (v == 10*i+6) eh[i] = 1'b1;
            end
            push(0, 0, rtun, 0, 0, etun, 0, eh, 1, 4'h0);
        end
        // Tunnel 2 stuck 40 cycles: fault after 32 debounced-low cycles, sticky
        for (int v = 1; v <= 50; v++)
            push(0, 0, (v <= 40) ? 4'b1011 : 4'hF, 0, 0,
                 (v >= 6 && v <= 45) ? 4'b1011 : 4'hF, 0,
                 (v == 6) ? 4'b0100 : 4'h0, 1, (v >= 38) ? 4'b0100 : 4'h0);

        // Reset state while held in reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_target",   -1, {3'b0, bus.target},     4'h0);
        chk("rst_lose",     -1, {3'b0, bus.lose_arch},  4'h0);
        chk("rst_tunnel",   -1, bus.tunnel_p,           4'hF);
        chk("rst_thit",     -1, {3'b0, bus.target_hit}, 4'h0);
        chk("rst_tunhit",   -1, bus.tunnel_hit,         4'h0);
        chk("rst_enable",   -1, {3'b0, bus.enable_FSM}, 4'h0);
        chk("rst_fault",    -1, bus.sensor_fault,       4'h0);
        reset = 1'b1;

        for (int i = 0; i < vq.size(); i++)
            run_vec(vq[i], i);

        // Reset while lose arch is mid-debounce, then full settle again
        bus.raw_lose_arch = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        chk("mid_lose_pre", 1000, {3'b0, bus.lose_arch}, 4'h0);
        reset = 1'b0;
        bus.raw_lose_arch = 1'b0;
        #1;
        chk("async_lose",   1000, {3'b0, bus.lose_arch},  4'h0);
        chk("async_enable", 1000, {3'b0, bus.enable_FSM}, 4'h0);
        chk("async_fault",  1000, bus.sensor_fault,       4'h0);
        chk("async_tunnel", 1000, bus.tunnel_p,           4'hF);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int v = 1; v <= 8; v++) begin
            idle_v.rt = 0; idle_v.rl = 0; idle_v.rtun = 4'hF;
            idle_v.et = 0; idle_v.el = 0; idle_v.etun = 4'hF;
            idle_v.eth = 0; idle_v.etunh = 4'h0; idle_v.een = (v == 8); idle_v.ef = 4'h0;
            run_vec(idle_v, 2000 + v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_pinball_input_cond
